// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared Morse symbol encoding, timing units and keyer state
//                encoding used by both the transmit keyer and receive decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

  // Symbol encoding: one bit per symbol, shared with the receive decoder
  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  // Durations in Morse time units
  localparam logic [2:0] DOT_UNITS        = 3'd1;
  localparam logic [2:0] DASH_UNITS       = 3'd3;
  localparam logic [2:0] SYM_GAP_UNITS    = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS   = 3'd3;
  localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

  localparam int MAX_SYMBOLS = 6;

  // Keyer state encoding
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MARK     = 2'd1,
    ST_SPACE    = 2'd2,
    ST_CHAR_GAP = 2'd3
  } keyer_state_t;

endpackage : morse_pkg
`default_nettype wire

// File: rtl/morse_unit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_unit_timer
//  Description : Prescaler plus units-remaining down-counter. A start pulse
//                restarts the prescaler and loads the unit count; done pulses
//                on the prescaler wrap in which the last unit expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 10000000,
  parameter int UNITS_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [UNITS_W-1:0] units,
  output logic               done
);

  localparam int            PW        = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(UNIT_CYCLES - 1);

  logic [PW-1:0]      presc;
  logic [UNITS_W-1:0] remaining;
  logic               active;
  logic               wrap;

  assign wrap = active && (presc == PRESC_TOP);
  // Exit on the wrap that consumes the final unit, so lengths are exact multiples
  assign done = wrap && (remaining == UNITS_W'(1));

  // Prescaler and unit down-counter; start has priority over a coincident wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      remaining <= '0;
      active    <= 1'b0;
    end else if (start) begin
      presc     <= '0;
      remaining <= units;
      active    <= (units != '0);
    end else if (active) begin
      if (wrap) begin
        presc     <= '0;
        remaining <= remaining - UNITS_W'(1);
        if (remaining == UNITS_W'(1)) begin
          active <= 1'b0;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule : morse_unit_timer
`default_nettype wire

// File: rtl/morse_keyer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_keyer
//  Description : Transmit-side Morse keyer. Accepts one encoded character per
//                valid/ready handshake and plays it out as a timed key level.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_keyer #(
  parameter int UNIT_CYCLES = 10000000,
  parameter int MAX_SYMBOLS = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MAX_SYMBOLS-1:0] sym_pattern,
  input  logic [2:0]             sym_count,
  input  logic                   char_valid,
  output logic                   char_ready,
  output logic                   key_out,
  output logic                   busy,
  output logic                   char_done
);

  import morse_pkg::*;

  localparam logic [2:0] MAX_CNT = 3'(MAX_SYMBOLS);

  keyer_state_t           state;
  keyer_state_t           next_state;
  logic [MAX_SYMBOLS-1:0] shift_reg;
  logic [2:0]             remaining_syms;
  logic [2:0]             clamped_count;

  logic                   timer_start;
  logic [2:0]             timer_units;
  logic                   timer_done;
  logic                   load;
  logic                   advance;
  logic                   gap_end;

  assign clamped_count = (sym_count > MAX_CNT) ? MAX_CNT : sym_count;
  assign char_ready    = (state == ST_IDLE);

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .UNITS_W     (3)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start),
    .units (timer_units),
    .done  (timer_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode, timer reloads and datapath strobes
  always_comb begin
    next_state  = state;
    timer_start = 1'b0;
    timer_units = 3'd0;
    load        = 1'b0;
    advance     = 1'b0;
    gap_end     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (char_valid) begin
          load        = 1'b1;
          timer_start = 1'b1;
          if (clamped_count == 3'd0) begin
            next_state  = ST_CHAR_GAP;
            timer_units = WORD_EXTRA_UNITS;
          end else begin
            next_state  = ST_MARK;
            timer_units = (sym_pattern[0] == DASH) ? DASH_UNITS : DOT_UNITS;
          end
        end
      end
      ST_MARK: begin
        if (timer_done) begin
          advance     = 1'b1;
          timer_start = 1'b1;
          if (remaining_syms > 3'd1) begin
            next_state  = ST_SPACE;
            timer_units = SYM_GAP_UNITS;
          end else begin
            next_state  = ST_CHAR_GAP;
            timer_units = CHAR_GAP_UNITS;
          end
        end
      end
      ST_SPACE: begin
        if (timer_done) begin
          // Pattern was already shifted at the end of the previous mark
          next_state  = ST_MARK;
          timer_start = 1'b1;
          timer_units = (shift_reg[0] == DASH) ? DASH_UNITS : DOT_UNITS;
        end
      end
      ST_CHAR_GAP: begin
        if (timer_done) begin
          next_state = ST_IDLE;
          gap_end    = 1'b1;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Symbol shift register, remaining count and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg      <= '0;
      remaining_syms <= 3'd0;
      key_out        <= 1'b0;
      busy           <= 1'b0;
      char_done      <= 1'b0;
    end else begin
      key_out   <= (next_state == ST_MARK);
      busy      <= (next_state != ST_IDLE);
      char_done <= gap_end;
      if (load) begin
        shift_reg      <= sym_pattern;
        remaining_syms <= clamped_count;
      end else if (advance) begin
        shift_reg      <= shift_reg >> 1;
        remaining_syms <= remaining_syms - 3'd1;
      end
    end
  end

endmodule : morse_keyer
`default_nettype wire

// File: tb/tb_morse_keyer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_keyer
//  Description : Scoreboard bench for morse_keyer with a cycle-level reference
//                waveform built from Morse timing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_keyer;

  localparam int UC = 4;
  localparam int MS = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MS-1:0] sym_pattern = '0;
  logic [2:0]    sym_count = 3'd0;
  logic          char_valid = 1'b0;
  logic          char_ready;
  logic          key_out;
  logic          busy;
  logic          char_done;

  typedef struct packed {
    logic key;
    logic bsy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  morse_keyer #(
    .UNIT_CYCLES (UC),
    .MAX_SYMBOLS (MS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sym_pattern (sym_pattern),
    .sym_count   (sym_count),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .key_out     (key_out),
    .busy        (busy),
    .char_done   (char_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_level(input logic lvl, input int cycles);
    exp_t e;
    e.key  = lvl;
    e.bsy  = 1'b1;
    e.done = 1'b0;
    for (int i = 0; i < cycles; i++) exp_q.push_back(e);
  endtask

  // Reference waveform: marks of 1/3 units, 1-unit spaces, 3-unit trailing gap,
  // or 4 silent units for a word space; then one idle cycle carrying char_done
  task automatic push_char(input logic [MS-1:0] pat, input logic [2:0] cnt);
    int   n;
    exp_t e;
    n = (int'(cnt) > MS) ? MS : int'(cnt);
    if (n == 0) begin
      push_level(1'b0, 4 * UC);
    end else begin
      for (int s = 0; s < n; s++) begin
        push_level(1'b1, (pat[s] ? 3 : 1) * UC);
        if (s < n - 1) push_level(1'b0, UC);
      end
      push_level(1'b0, 3 * UC);
    end
    e.key  = 1'b0;
    e.bsy  = 1'b0;
    e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Offer a character and wait (bounded) for the handshake
  task automatic send(input logic [MS-1:0] pat, input logic [2:0] cnt, input bit hold);
    int waited;
    waited      = 0;
    sym_pattern = pat;
    sym_count   = cnt;
    char_valid  = 1'b1;
    @(negedge clk);
    while (!char_ready) begin
      waited++;
      if (waited > 2000) begin
        check("ready_timeout", 0, 1);
        char_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    push_char(pat, cnt);
    @(posedge clk);
    #1;
    if (hold) begin
      // Keep offering junk while busy; it must be ignored
      sym_pattern = MS'($urandom);
      sym_count   = 3'($urandom);
    end else begin
      char_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    char_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pop one expected entry per cycle in which the DUT is active
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy || char_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_activity", int'({busy, char_done}), 0);
        end else begin
          e = exp_q.pop_front();
          check("key_out", int'(key_out), int'(e.key));
          check("busy", int'(busy), int'(e.bsy));
          check("char_done", int'(char_done), int'(e.done));
          check("char_ready", int'(char_ready), int'(e.done));
        end
      end else begin
        check("idle_key_out", int'(key_out), 0);
        check("idle_ready", int'(char_ready), 1);
      end
    end
  end

  // Stimulus
  initial begin
    int waited;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_key_out", int'(key_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_char_done", int'(char_done), 0);
    check("rst_char_ready", int'(char_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // "E", then "A"
    send(6'b000000, 3'd1, 1'b0);
    idle(3);
    send(6'b000010, 3'd2, 1'b0);
    idle(2);

    // "E" followed immediately by a word space
    send(6'b000000, 3'd1, 1'b1);
    send(6'b101010, 3'd0, 1'b0);
    idle(2);

    // Back-to-back "T" then "E" with valid held
    send(6'b000001, 3'd1, 1'b1);
    send(6'b000000, 3'd1, 1'b0);
    idle(2);

    // Count above maximum is clamped to six dashes
    send(6'b111111, 3'd7, 1'b0);
    idle(2);

    // Reset during "A": assert in cycle 10, valid offered while in reset
    send(6'b000010, 3'd2, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst         = 1'b1;
    char_valid  = 1'b1;
    sym_pattern = 6'b000001;
    sym_count   = 3'd1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check("abort_key_out", int'(key_out), 0);
    check("abort_ready", int'(char_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_char_done", int'(char_done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    char_valid = 1'b0;
    idle(3);

    // Randomised characters, gaps and back-to-back holds
    for (int k = 0; k < 30; k++) begin
      bit hold;
      hold = 1'($urandom_range(0, 1));
      send(MS'($urandom), 3'($urandom_range(0, 7)), hold);
      if (!hold) idle($urandom_range(0, 3));
    end
    idle(1);

    // Drain the scoreboard
    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    idle(2);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_morse_keyer
`default_nettype wire
